ddr_rd_packer: RTL

Collects a stream of 256-bit DDR read beats into 16-beat (4096-bit) lines and presents each completed line to `mem_demux` as a single-cycle `data_valid` pulse. It provides `base_addr`, `last` and `num_of_last_valid` for each line. It sits directly upstream of `mem_demux`, between the DDR read-data channel and the SRAM write path. One transfer is programmed per `start` pulse.

---
 rtl/mem_pkg.sv | 18 +
 rtl/ddr_line_buf.sv | 42 ++++
 rtl/ddr_rd_packer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared constants, line type and packer FSM encoding for the DDR read path.
package mem_pkg;

    localparam int BEAT_W = 256;             // bits per DDR beat / SRAM word
    localparam int BEATS  = 16;              // beats per line
    localparam int ADDR_W = 19;              // address width in beat units
    localparam int LEN_W  = 16;              // transfer length width in beats
    localparam int IDX_W  = $clog2(BEATS);   // slot index width

    typedef logic [BEATS-1:0][BEAT_W-1:0] line_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        LAST = 2'd2
    } pack_state_e;

endpackage

// File: rtl/ddr_line_buf.sv
// 16-slot line register: one indexed beat write per cycle, and a clear of
// every slot that is not being written on the edge that ends an emitted line.
module ddr_line_buf
    import mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [BEAT_W-1:0] wr_data,
    input  logic              clr,
    output line_t             line
);

    line_t line_q;
    line_t line_d;

    // Next slot contents: a write wins over the clear, so the first beat of the
    // following line can land in slot 0 while the old line is being sampled.
    always_comb begin
        line_d = line_q;
        for (int i = 0; i < BEATS; i++) begin
            if (wr_en && (wr_idx == IDX_W'(i))) begin
                line_d[i] = wr_data;
            end else if (clr) begin
                line_d[i] = '0;
            end
        end
    end

    // Slot storage register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else begin
            line_q <= line_d;
        end
    end

    assign line = line_q;

endmodule

// File: rtl/ddr_rd_packer.sv
// Packs a stream of DDR read beats into 16-beat lines and emits each line as a
// single-cycle strobe with its base address, last flag and valid-beat count.
//
// Handshake: a DDR beat transfers on a rising edge where ddr_valid and
// ddr_ready are both high; ddr_ready depends only on the state (high in FILL),
// never on ddr_valid. The output side has no backpressure: data_valid is a
// one-cycle pulse and the line must be consumed in that cycle.
module ddr_rd_packer
    import mem_pkg::*;
(
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [ADDR_W-1:0]            start_addr,
    input  logic [LEN_W-1:0]             num_beats,
    output logic                         busy,
    output logic                         done,
    input  logic [BEAT_W-1:0]            ddr_data,
    input  logic                         ddr_valid,
    output logic                         ddr_ready,
    output logic [BEATS-1:0][BEAT_W-1:0] data_out,
    output logic                         data_valid,
    output logic [ADDR_W-1:0]            base_addr,
    output logic                         last,
    output logic [3:0]                   num_of_last_valid
);

    pack_state_e       state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  rem_q, rem_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic              strobe_q, strobe_d;
    logic [IDX_W-1:0]  nolv_q, nolv_d;

    logic              hs;
    logic              emit;
    line_t             line;

    // A beat is taken whenever the source offers one while filling.
    assign hs   = ddr_valid && (state_q == FILL);
    // Full lines strobe from a flag; the final line strobes from the LAST state.
    assign emit = strobe_q || (state_q == LAST);

    // FSM, slot index, remaining count, base address and line metadata.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rem_d    = rem_q;
        base_d   = base_q;
        strobe_d = 1'b0;
        nolv_d   = nolv_q;

        // The address advances once per emitted line, at the edge closing it.
        if (emit) begin
            base_d = base_q + ADDR_W'(BEATS);
        end

        case (state_q)
            IDLE: begin
                if (start && (num_beats != '0)) begin
                    state_d = FILL;
                    base_d  = start_addr;
                    rem_d   = num_beats;
                    idx_d   = '0;
                end
            end
            FILL: begin
                if (hs) begin
                    idx_d = idx_q + IDX_W'(1);
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        // Final beat: its slot index is the valid count minus 1.
                        state_d = LAST;
                        nolv_d  = idx_q;
                    end else if (idx_q == IDX_W'(BEATS - 1)) begin
                        strobe_d = 1'b1;
                        nolv_d   = IDX_W'(BEATS - 1);
                    end
                end
            end
            LAST: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Control and metadata registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rem_q    <= '0;
            base_q   <= '0;
            strobe_q <= 1'b0;
            nolv_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rem_q    <= rem_d;
            base_q   <= base_d;
            strobe_q <= strobe_d;
            nolv_q   <= nolv_d;
        end
    end

    ddr_line_buf u_line_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (hs),
        .wr_idx  (idx_q),
        .wr_data (ddr_data),
        .clr     (emit),
        .line    (line)
    );

    assign busy              = (state_q != IDLE);
    assign ddr_ready         = (state_q == FILL);
    assign data_valid        = emit;
    assign last              = (state_q == LAST);
    assign done              = (state_q == LAST);
    assign base_addr         = base_q;
    assign num_of_last_valid = nolv_q;
    assign data_out          = line;

endmodule
